// File: rtl/exe_stage_unit_if.sv
// Bundle between the ID/EXE register, the execute stage and the MEM stage.
// The master drives the decoded instruction fields; the slave (execute stage) returns results.
interface exe_stage_unit_if #(
  parameter int unsigned FWD_SEL_W = 2
);
  // ID/EXE side
  logic                 freeze;
  logic                 wb_en_in;
  logic                 mem_r_en_in;
  logic                 mem_w_en_in;
  logic                 b_in;
  logic                 s_in;
  logic [3:0]           exe_cmd;
  logic [31:0]          pc_in;
  logic [31:0]          val_rn;
  logic [31:0]          val_rm;
  logic                 imm;
  logic [11:0]          shift_operand;
  logic [23:0]          signed_imm24;
  logic [3:0]           dest_in;
  logic [FWD_SEL_W-1:0] sel_src1;
  logic [FWD_SEL_W-1:0] sel_src2;
  logic [31:0]          fwd_mem_val;
  logic [31:0]          fwd_wb_val;

  // Results towards fetch, decode and MEM
  logic                 branch_taken;
  logic [31:0]          branch_addr;
  logic [3:0]           status;
  logic                 wb_en;
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic [31:0]          alu_res;
  logic [31:0]          st_val;
  logic [3:0]           dest;

  modport master (
    output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd, pc_in,
           val_rn, val_rm, imm, shift_operand, signed_imm24, dest_in, sel_src1, sel_src2,
           fwd_mem_val, fwd_wb_val,
    input  branch_taken, branch_addr, status, wb_en, mem_r_en, mem_w_en, alu_res, st_val, dest
  );

  modport slave (
    input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd, pc_in,
           val_rn, val_rm, imm, shift_operand, signed_imm24, dest_in, sel_src1, sel_src2,
           fwd_mem_val, fwd_wb_val,
    output branch_taken, branch_addr, status, wb_en, mem_r_en, mem_w_en, alu_res, st_val, dest
  );
endinterface

// File: rtl/exe_stage_unit.sv
// ARM execute stage: Val2 shifter, ALU, NZCV status register, branch target and EXE/MEM register.
// Define EXE_FWD_EN to enable the operand forwarding muxes on Rn and Rm.
module exe_stage_unit (
  input  logic            clk,
  input  logic            rst,
  exe_stage_unit_if.slave bus
);

  logic [3:0]  status_q;
  logic        wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [31:0] alu_res_q, st_val_q;
  logic [3:0]  dest_q;

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
  logic [31:0] op_a, op_rm;

  always_comb begin
    op_a  = bus.val_rn;
    op_rm = bus.val_rm;
`ifdef EXE_FWD_EN
    // Select 3 is unused and falls back to the ID value.
    case (int'(bus.sel_src1))
      1:       op_a = bus.fwd_mem_val;
      2:       op_a = bus.fwd_wb_val;
      default: op_a = bus.val_rn;
    endcase
    case (int'(bus.sel_src2))
      1:       op_rm = bus.fwd_mem_val;
      2:       op_rm = bus.fwd_wb_val;
      default: op_rm = bus.val_rm;
    endcase
`endif
  end

  // ---------------------------------------------------------------------------
  // Val2 generation
  // ---------------------------------------------------------------------------
  logic [4:0]  rot_amt, sh_amt;
  logic [31:0] imm32, imm_rot, rm_rot, val2;

  always_comb begin
    rot_amt = {bus.shift_operand[11:8], 1'b0};
    sh_amt  = bus.shift_operand[11:7];
    imm32   = {24'b0, bus.shift_operand[7:0]};
    // Rotations via a doubled word shifted right.
    imm_rot = 32'({imm32, imm32} >> rot_amt);
    rm_rot  = 32'({op_rm, op_rm} >> sh_amt);
    val2    = '0;
    if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      val2 = {20'b0, bus.shift_operand};
    end else if (bus.imm) begin
      val2 = imm_rot;
    end else begin
      unique case (bus.shift_operand[6:5])
        2'b00:   val2 = op_rm << sh_amt;
        2'b01:   val2 = op_rm >> sh_amt;
        2'b10:   val2 = 32'($signed(op_rm) >>> sh_amt);
        default: val2 = rm_rot;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ALU and flag generation
  // ---------------------------------------------------------------------------
  logic [31:0] alu_res_d, add_b;
  logic        add_cin, add_v, is_arith, is_valid;
  logic [32:0] sum;
  logic [3:0]  flags_d;

  always_comb begin
    alu_res_d = '0;
    add_b     = val2;
    add_cin   = 1'b0;
    is_arith  = 1'b0;
    is_valid  = 1'b1;
    case (bus.exe_cmd)
      4'b0001: alu_res_d = val2;
      4'b1001: alu_res_d = ~val2;
      4'b0010: is_arith = 1'b1;
      4'b0011: begin
        is_arith = 1'b1;
        add_cin  = status_q[1];
      end
      // Subtraction as A + ~B + carry-in, so the carry-out is NOT borrow.
      4'b0100: begin
        is_arith = 1'b1;
        add_b    = ~val2;
        add_cin  = 1'b1;
      end
      4'b0101: begin
        is_arith = 1'b1;
        add_b    = ~val2;
        add_cin  = status_q[1];
      end
      4'b0110: alu_res_d = op_a & val2;
      4'b0111: alu_res_d = op_a | val2;
      4'b1000: alu_res_d = op_a ^ val2;
      default: is_valid = 1'b0;
    endcase

    sum = {1'b0, op_a} + {1'b0, add_b} + {32'b0, add_cin};
    if (is_arith) begin
      alu_res_d = sum[31:0];
    end
    add_v = (op_a[31] == add_b[31]) && (sum[31] != op_a[31]);

    flags_d = status_q;
    if (is_valid) begin
      flags_d = {alu_res_d[31], (alu_res_d == 32'd0),
                 is_arith ? sum[32] : status_q[1],
                 is_arith ? add_v   : status_q[0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Status and EXE/MEM registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q   <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
    end else if (!bus.freeze) begin
      wb_en_q    <= bus.wb_en_in;
      mem_r_en_q <= bus.mem_r_en_in;
      mem_w_en_q <= bus.mem_w_en_in;
      alu_res_q  <= alu_res_d;
      st_val_q   <= op_rm;
      dest_q     <= bus.dest_in;
      if (bus.s_in) begin
        status_q <= flags_d;
      end
    end
  end

  assign bus.branch_taken = bus.b_in;
  assign bus.branch_addr  = bus.pc_in + {{6{bus.signed_imm24[23]}}, bus.signed_imm24, 2'b00};
  assign bus.status       = status_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.mem_r_en     = mem_r_en_q;
  assign bus.mem_w_en     = mem_w_en_q;
  assign bus.alu_res      = alu_res_q;
  assign bus.st_val       = st_val_q;
  assign bus.dest         = dest_q;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed plus randomized bench for exe_stage_unit against an arithmetic reference model.
module tb_exe_stage_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_stage_unit_if #(.FWD_SEL_W(2)) bus ();

  exe_stage_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [3:0]  m_status;
  logic [31:0] e_alu, e_st;
  logic [3:0]  e_dest;
  logic [2:0]  e_ctl;

  logic [31:0] edge_vals [4] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string pfx);
    chk({pfx, "_alu_res"}, bus.alu_res, e_alu);
    chk({pfx, "_st_val"}, bus.st_val, e_st);
    chk({pfx, "_dest"}, 32'(bus.dest), 32'(e_dest));
    chk({pfx, "_ctl"}, 32'({bus.wb_en, bus.mem_r_en, bus.mem_w_en}), 32'(e_ctl));
    chk({pfx, "_status"}, 32'(bus.status), 32'(m_status));
  endtask

  task automatic model_clear();
    m_status = '0;
    e_alu    = '0;
    e_st     = '0;
    e_dest   = '0;
    e_ctl    = '0;
  endtask

  function automatic logic [31:0] m_val2(input logic [11:0] so, input logic [31:0] rm,
                                         input logic imm, input logic mem);
    logic [31:0] v;
    int n;
    if (mem) return 32'(so);
    if (imm) begin
      v = 32'(so[7:0]);
      n = 2 * int'(so[11:8]);
      for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
      return v;
    end
    v = rm;
    n = int'(so[11:7]);
    case (so[6:5])
      2'd0: v = rm << n;
      2'd1: v = rm >> n;
      2'd2: for (int i = 0; i < n; i++) v = {v[31], v[31:1]};
      default: for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
    endcase
    return v;
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] st, output logic [31:0] res,
                                output logic [3:0] fl);
    longint ua, ub, sa, sb, u, s, k;
    logic c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = st[1];
    v  = st[0];
    res = '0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2, 4'd3: begin
        k = (cmd == 4'd3 && st[1]) ? 1 : 0;
        u = ua + ub + k;
        s = sa + sb + k;
        res = 32'(u);
        c = (u > 64'sd4294967295);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        k = (cmd == 4'd5 && !st[1]) ? 1 : 0;
        u = ua - ub - k;
        s = sa - sb - k;
        res = 32'(u);
        c = (u >= 0);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: begin
        fl = st;
        return;
      end
    endcase
    fl = {res[31], (res == 32'd0), c, v};
  endfunction

  function automatic logic [31:0] m_baddr(input logic [31:0] pc, input logic [23:0] off24);
    longint off;
    off = longint'(off24);
    if (off24[23]) off = off - 16777216;
    return 32'(longint'(pc) + off * 4);
  endfunction

  // One clock of stimulus: comb checks before the edge, register checks after it.
  task automatic cycle(input string tag);
    logic [31:0] a, rm, v2, res, ba;
    logic [3:0]  fl;
    #1;
    a  = bus.val_rn;
    rm = bus.val_rm;
`ifdef EXE_FWD_EN
    if (bus.sel_src1 == 2'd1) a = bus.fwd_mem_val;
    else if (bus.sel_src1 == 2'd2) a = bus.fwd_wb_val;
    if (bus.sel_src2 == 2'd1) rm = bus.fwd_mem_val;
    else if (bus.sel_src2 == 2'd2) rm = bus.fwd_wb_val;
`endif
    v2 = m_val2(bus.shift_operand, rm, bus.imm, bus.mem_r_en_in | bus.mem_w_en_in);
    m_alu(bus.exe_cmd, a, v2, m_status, res, fl);
    ba = m_baddr(bus.pc_in, bus.signed_imm24);
    chk({tag, "_br_taken"}, 32'(bus.branch_taken), 32'(bus.b_in));
    chk({tag, "_br_addr"}, bus.branch_addr, ba);
    @(posedge clk);
    #1;
    if (!bus.freeze) begin
      e_alu  = res;
      e_st   = rm;
      e_dest = bus.dest_in;
      e_ctl  = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in};
      if (bus.s_in) m_status = fl;
    end
    chk_regs(tag);
  endtask

  task automatic nop();
    bus.freeze        = 1'b0;
    bus.wb_en_in      = 1'b0;
    bus.mem_r_en_in   = 1'b0;
    bus.mem_w_en_in   = 1'b0;
    bus.b_in          = 1'b0;
    bus.s_in          = 1'b0;
    bus.exe_cmd       = 4'd0;
    bus.pc_in         = '0;
    bus.val_rn        = '0;
    bus.val_rm        = '0;
    bus.imm           = 1'b0;
    bus.shift_operand = '0;
    bus.signed_imm24  = '0;
    bus.dest_in       = '0;
    bus.sel_src1      = '0;
    bus.sel_src2      = '0;
    bus.fwd_mem_val   = '0;
    bus.fwd_wb_val    = '0;
  endtask

  task automatic randomize_inputs();
    bus.freeze        = ($urandom_range(0, 7) == 0);
    bus.wb_en_in      = 1'($urandom_range(0, 1));
    bus.mem_r_en_in   = ($urandom_range(0, 5) == 0);
    bus.mem_w_en_in   = ($urandom_range(0, 5) == 0);
    bus.b_in          = 1'($urandom_range(0, 1));
    bus.s_in          = 1'($urandom_range(0, 1));
    bus.exe_cmd       = 4'($urandom_range(0, 15));
    bus.pc_in         = $urandom;
    bus.val_rn        = $urandom;
    bus.val_rm        = $urandom;
    if ($urandom_range(0, 3) == 0) bus.val_rn = edge_vals[$urandom_range(0, 3)];
    if ($urandom_range(0, 3) == 0) bus.val_rm = edge_vals[$urandom_range(0, 3)];
    bus.imm           = 1'($urandom_range(0, 1));
    bus.shift_operand = 12'($urandom);
    bus.signed_imm24  = 24'($urandom);
    bus.dest_in       = 4'($urandom);
    bus.sel_src1      = 2'($urandom_range(0, 3));
    bus.sel_src2      = 2'($urandom_range(0, 3));
    bus.fwd_mem_val   = $urandom;
    bus.fwd_wb_val    = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    model_clear();
    randomize_inputs();
    bus.freeze = 1'b0;
    bus.s_in   = 1'b1;
    #2 rst = 1'b0;
    #1 chk_regs("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_regs("rst_held");
    @(negedge clk);
    rst = 1'b1;

    // ADD 5 + #3 with S
    nop();
    bus.val_rn = 32'd5; bus.imm = 1'b1; bus.shift_operand = 12'h003;
    bus.exe_cmd = 4'd2; bus.s_in = 1'b1; bus.wb_en_in = 1'b1; bus.dest_in = 4'd4;
    cycle("add");
    chk("add_const", bus.alu_res, 32'd8);
    chk("add_nzcv", 32'(bus.status), 32'h0);

    // SUB 3 - #3 with S -> Z and C set
    nop();
    bus.val_rn = 32'd3; bus.imm = 1'b1; bus.shift_operand = 12'h003;
    bus.exe_cmd = 4'd4; bus.s_in = 1'b1;
    cycle("sub");
    chk("sub_const", bus.alu_res, 32'd0);
    chk("sub_nzcv", 32'(bus.status), 32'h6);

    // ADC 0 + #0 + C
    nop();
    bus.imm = 1'b1; bus.exe_cmd = 4'd3;
    cycle("adc");
    chk("adc_const", bus.alu_res, 32'd1);

    // MOV immediate 0xFF ror 8 with S -> N set, C kept
    nop();
    bus.imm = 1'b1; bus.shift_operand = 12'h4FF; bus.exe_cmd = 4'd1; bus.s_in = 1'b1;
    cycle("rot");
    chk("rot_const", bus.alu_res, 32'hFF00_0000);
    chk("rot_nzcv", 32'(bus.status), 32'hA);

    // MOV Rm ASR #1
    nop();
    bus.val_rm = 32'h8000_0000; bus.shift_operand = 12'h0C0; bus.exe_cmd = 4'd1;
    cycle("asr");
    chk("asr_const", bus.alu_res, 32'hC000_0000);

    // Backward branch, combinational target
    nop();
    bus.pc_in = 32'h100; bus.signed_imm24 = 24'hFFFFFE; bus.b_in = 1'b1;
    #1;
    chk("br_const_taken", 32'(bus.branch_taken), 32'd1);
    chk("br_const_addr", bus.branch_addr, 32'h0000_00F8);
    cycle("br");

    // Frozen S instruction must not touch any register
    nop();
    bus.freeze = 1'b1; bus.val_rn = 32'd0; bus.imm = 1'b1; bus.shift_operand = 12'h001;
    bus.exe_cmd = 4'd4; bus.s_in = 1'b1; bus.dest_in = 4'd9;
    cycle("frz");
    chk("frz_status", 32'(bus.status), 32'hA);

    // Forwarded Rn from the MEM stage
    nop();
    bus.sel_src1 = 2'd1; bus.fwd_mem_val = 32'd10; bus.imm = 1'b1;
    bus.shift_operand = 12'h001; bus.exe_cmd = 4'd2;
    cycle("fwd");
`ifdef EXE_FWD_EN
    chk("fwd_const", bus.alu_res, 32'd11);
`else
    chk("fwd_const", bus.alu_res, 32'd1);
`endif

    // Reset asserted while frozen still clears everything
    nop();
    bus.val_rn = 32'h1234; bus.imm = 1'b1; bus.shift_operand = 12'h001;
    bus.exe_cmd = 4'd2; bus.s_in = 1'b1; bus.wb_en_in = 1'b1; bus.dest_in = 4'd7;
    cycle("pre_rst");
    bus.freeze = 1'b1;
    #2 rst = 1'b0;
    model_clear();
    #1 chk_regs("rst_frz");
    @(negedge clk);
    rst = 1'b1;
    bus.freeze = 1'b0;

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
